// File: rtl/birrd_cmd_issuer.sv
// birrd_cmd_issuer
// Sequences per-beat network commands for a BIRRD reduction/redistribution
// network. A small command table is loaded while idle; a run then streams
// upstream beats into the network, attaching table[entry] to each beat and
// walking the table num_iter times. After the final beat the issuer keeps
// the network enabled for TOTAL_STAGE cycles so that beat can leave the
// pipeline, then pulses done.
//
// Handshake: an upstream beat transfers in a cycle where s_valid and s_ready
// are both 1. s_ready depends only on the FSM state (1 in RUN), never on
// s_valid, so the upstream side may hold or drop s_valid freely and a beat
// presented while s_ready=0 is simply not taken.
module birrd_cmd_issuer #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_INPUT_DATA = 16,
    parameter int COMMAND_WIDTH  = 2,
    parameter int DEPTH          = 8,
    localparam int LEVEL            = $clog2(NUM_INPUT_DATA),
    localparam int TOTAL_STAGE      = 2 * LEVEL - 1,
    localparam int IN_COMMAND_WIDTH = COMMAND_WIDTH * TOTAL_STAGE,
    localparam int TOTAL_COMMAND    = (NUM_INPUT_DATA / 2) * IN_COMMAND_WIDTH,
    localparam int AW               = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    // command table configuration
    input  logic                                 cfg_we,
    input  logic [AW-1:0]                        cfg_addr,
    input  logic [TOTAL_COMMAND-1:0]             cfg_wdata,
    input  logic [AW:0]                          cfg_num_entries,
    input  logic [15:0]                          cfg_num_iter,
    input  logic                                 start,
    // upstream beat stream
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [NUM_INPUT_DATA-1:0]            s_lane_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] s_data,
    // network side
    output logic [NUM_INPUT_DATA-1:0]            o_valid,
    output logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
    output logic                                 o_en,
    output logic [TOTAL_COMMAND-1:0]             o_cmd,
    // status
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic [1:0]                           dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int DRAIN_W = $clog2(TOTAL_STAGE + 1);

    logic [1:0]                           state_q, state_d;
    logic [AW:0]                          num_entries_q, num_entries_d;
    logic [15:0]                          num_iter_q, num_iter_d;
    logic [AW-1:0]                        entry_q, entry_d;
    logic [15:0]                          iter_q, iter_d;
    logic [DRAIN_W-1:0]                   drain_q, drain_d;
    logic                                 done_q, done_d;
    logic                                 err_q, err_d;

    logic [TOTAL_COMMAND-1:0]             table_q [DEPTH];

    logic [NUM_INPUT_DATA-1:0]            o_valid_q;
    logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] o_data_q;
    logic [TOTAL_COMMAND-1:0]             o_cmd_q;

    logic                                 hs;
    logic                                 cfg_ok;
    logic                                 last_entry;
    logic                                 last_iter;
    logic                                 table_we;

    // Handshake, config validity and end-of-table decodes
    always_comb begin
        hs         = s_valid && (state_q == ST_RUN);
        cfg_ok     = (cfg_num_entries != '0) &&
                     (cfg_num_entries <= (AW+1)'(DEPTH)) &&
                     (cfg_num_iter != 16'd0);
        last_entry = ({1'b0, entry_q} == (num_entries_q - 1'b1));
        last_iter  = (iter_q == (num_iter_q - 16'd1));
        table_we   = cfg_we && (state_q == ST_IDLE);
    end

    // Run control: state, table walk pointers, drain timer, done/err
    always_comb begin
        state_d       = state_q;
        num_entries_d = num_entries_q;
        num_iter_d    = num_iter_q;
        entry_d       = entry_q;
        iter_d        = iter_q;
        drain_d       = drain_q;
        done_d        = 1'b0;
        err_d         = err_q;

        // A table write attempted mid-run is dropped and flagged.
        if (cfg_we && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        num_entries_d = cfg_num_entries;
                        num_iter_d    = cfg_num_iter;
                        entry_d       = '0;
                        iter_d        = '0;
                        state_d       = ST_RUN;
                    end else begin
                        // Rejected run: report completion so a waiting host
                        // does not stall, and leave err set.
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    if (last_entry) begin
                        entry_d = '0;
                        if (last_iter) begin
                            drain_d = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            iter_d = iter_q + 16'd1;
                        end
                    end else begin
                        entry_d = entry_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Keep the network enabled until the last beat has crossed
                // every stage.
                if (drain_q == DRAIN_W'(TOTAL_STAGE - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            num_entries_q <= '0;
            num_iter_q    <= '0;
            entry_q       <= '0;
            iter_q        <= '0;
            drain_q       <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_entries_q <= num_entries_d;
            num_iter_q    <= num_iter_d;
            entry_q       <= entry_d;
            iter_q        <= iter_d;
            drain_q       <= drain_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Command table; reset contents are all-zero, i.e. pass-through commands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (table_we) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

    // Output stage: one-cycle registered copy of each accepted beat plus its
    // command; data/valid are zeroed on bubbles while the command is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= '0;
            o_data_q  <= '0;
            o_cmd_q   <= '0;
        end else begin
            if (hs) begin
                o_valid_q <= s_lane_valid;
                o_data_q  <= s_data;
                o_cmd_q   <= table_q[entry_q];
            end else begin
                o_valid_q <= '0;
                o_data_q  <= '0;
            end
        end
    end

    // Status and state-derived outputs
    always_comb begin
        s_ready     = (state_q == ST_RUN);
        busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        o_en        = busy;
        done        = done_q;
        err         = err_q;
        o_valid     = o_valid_q;
        o_data_bus  = o_data_q;
        o_cmd       = o_cmd_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_birrd_cmd_issuer.sv
// Testbench for birrd_cmd_issuer: directed scenarios with randomized data,
// lane masks and valid patterns, checked against a table/queue model.
module tb_birrd_cmd_issuer;

    localparam int DW    = 32;
    localparam int NI    = 16;
    localparam int CWID  = 2;
    localparam int DEPTH = 8;
    localparam int LEVEL = $clog2(NI);
    localparam int TS    = 2 * LEVEL - 1;
    localparam int TC    = (NI / 2) * CWID * TS;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = NI * DW;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [TC-1:0]  cfg_wdata;
    logic [AW:0]    cfg_num_entries;
    logic [15:0]    cfg_num_iter;
    logic           start;
    logic           s_valid;
    logic           s_ready;
    logic [NI-1:0]  s_lane_valid;
    logic [BW-1:0]  s_data;
    logic [NI-1:0]  o_valid;
    logic [BW-1:0]  o_data_bus;
    logic           o_en;
    logic [TC-1:0]  o_cmd;
    logic           busy;
    logic           done;
    logic           err;
    logic [1:0]     dbg_state;

    birrd_cmd_issuer #(
        .DATA_WIDTH     (DW),
        .NUM_INPUT_DATA (NI),
        .COMMAND_WIDTH  (CWID),
        .DEPTH          (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .cfg_num_entries (cfg_num_entries),
        .cfg_num_iter    (cfg_num_iter),
        .start           (start),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_lane_valid    (s_lane_valid),
        .s_data          (s_data),
        .o_valid         (o_valid),
        .o_data_bus      (o_data_bus),
        .o_en            (o_en),
        .o_cmd           (o_cmd),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .dbg_state_o     (dbg_state)
    );

    // scoreboard state
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [TC-1:0] mt [DEPTH];   // model of the command table
    logic          exp_err;
    logic [TC-1:0] last_cmd;     // command the network should currently see

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TC-1:0] rand_cmd();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[TC-1:0];
    endfunction

    function automatic logic [BW-1:0] rand_data();
        logic [BW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    // driver: table write while idle
    task automatic write_entry(input int addr, input logic [TC-1:0] w);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_wdata = w;
        tick();
        cfg_we    = 1'b0;
        mt[addr]  = w;
    endtask

    // driver + checker for one complete run.
    // mode 0: s_valid always 1, mode 1: 1,0,1,0..., mode 2: random.
    task automatic run_stream(input int ents, input int iters, input int mode,
                              input bit wr_in_run, input bit start_in_drain);
        int            beats;
        int            acc;
        int            cyc;
        logic          hs;
        logic [NI-1:0] lv;
        logic [BW-1:0] dat;
        beats = ents * iters;
        acc   = 0;
        cyc   = 0;
        cfg_num_entries = (AW+1)'(ents);
        cfg_num_iter    = 16'(iters);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_busy", BW'(busy), BW'(1'b1));
        chk("run_en", BW'(o_en), BW'(1'b1));
        chk("run_done_low", BW'(done), BW'(1'b0));
        while (acc < beats && cyc < 1000) begin
            chk("run_ready", BW'(s_ready), BW'(1'b1));
            chk("run_err", BW'(err), BW'(exp_err));
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            lv  = NI'($urandom);
            dat = rand_data();
            s_lane_valid = lv;
            s_data       = dat;
            if (wr_in_run && cyc == 0) begin
                cfg_we    = 1'b1;
                cfg_addr  = '0;
                cfg_wdata = ~mt[0];
                exp_err   = 1'b1;
            end
            hs = s_valid;
            if (hs) begin
                last_cmd = mt[acc % ents];
                acc++;
            end
            tick();
            cfg_we  = 1'b0;
            s_valid = 1'b0;
            chk("beat_valid", BW'(o_valid), hs ? BW'(lv) : '0);
            chk("beat_data", o_data_bus, hs ? dat : '0);
            chk("beat_cmd", BW'(o_cmd), BW'(last_cmd));
            cyc++;
        end
        if (acc != beats) chk("run_timeout", BW'(acc), BW'(beats));
        // drain: TS cycles after the last handshake, then done
        for (int d = 1; d <= TS; d++) begin
            chk("drain_ready", BW'(s_ready), BW'(1'b0));
            chk("drain_done", BW'(done), BW'(1'b0));
            chk("drain_en", BW'(o_en), BW'(1'b1));
            if (d >= 2) chk("drain_ovalid", BW'(o_valid), '0);
            chk("drain_cmd", BW'(o_cmd), BW'(last_cmd));
            s_valid = 1'($urandom_range(0, 1));
            s_lane_valid = '1;
            if (start_in_drain && d == 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        s_valid = 1'b0;
        chk("end_done", BW'(done), BW'(1'b1));
        chk("end_busy", BW'(busy), BW'(1'b0));
        chk("end_en", BW'(o_en), BW'(1'b0));
        chk("end_ready", BW'(s_ready), BW'(1'b0));
        chk("end_ovalid", BW'(o_valid), '0);
        chk("end_err", BW'(err), BW'(exp_err));
        tick();
        chk("post_done", BW'(done), BW'(1'b0));
        if (start_in_drain) begin
            for (int k = 0; k < 4; k++) begin
                chk("drain_start_busy", BW'(busy), BW'(1'b0));
                tick();
                chk("drain_start_done", BW'(done), BW'(1'b0));
            end
        end
    endtask

    // rejected start: no beats, done next cycle, err set
    task automatic bad_start(input int ents, input int iters);
        cfg_num_entries = (AW+1)'(ents);
        cfg_num_iter    = 16'(iters);
        start   = 1'b1;
        s_valid = 1'b1;
        tick();
        start   = 1'b0;
        exp_err = 1'b1;
        chk("bad_done", BW'(done), BW'(1'b1));
        chk("bad_busy", BW'(busy), BW'(1'b0));
        chk("bad_ready", BW'(s_ready), BW'(1'b0));
        chk("bad_ovalid", BW'(o_valid), '0);
        chk("bad_err", BW'(err), BW'(exp_err));
        tick();
        s_valid = 1'b0;
        chk("bad_done_clr", BW'(done), BW'(1'b0));
        chk("bad_ovalid2", BW'(o_valid), '0);
        chk("bad_ready2", BW'(s_ready), BW'(1'b0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ovalid"}, BW'(o_valid), '0);
        chk({tag, "_odata"}, o_data_bus, '0);
        chk({tag, "_ocmd"}, BW'(o_cmd), '0);
        chk({tag, "_oen"}, BW'(o_en), '0);
        chk({tag, "_ready"}, BW'(s_ready), '0);
        chk({tag, "_busy"}, BW'(busy), '0);
        chk({tag, "_done"}, BW'(done), '0);
        chk({tag, "_err"}, BW'(err), '0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cfg_num_entries = '0; cfg_num_iter = '0; start = 1'b0;
        s_valid = 1'b0; s_lane_valid = '0; s_data = '0;
        for (int i = 0; i < DEPTH; i++) mt[i] = '0;
        exp_err  = 1'b0;
        last_cmd = '0;

        // reset state
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // two-entry table, two iterations, back-to-back beats
        write_entry(0, rand_cmd());
        write_entry(1, rand_cmd());
        run_stream(2, 2, 0, 1'b0, 1'b0);

        // bubbles between beats
        write_entry(2, rand_cmd());
        run_stream(3, 2, 1, 1'b0, 1'b0);

        // full table, random shapes; one run gets a start during drain
        for (int i = 0; i < DEPTH; i++) write_entry(i, rand_cmd());
        for (int r = 0; r < 4; r++) begin
            run_stream($urandom_range(1, DEPTH), $urandom_range(1, 3), 2, 1'b0, r == 1);
        end
        run_stream(DEPTH, 1, 2, 1'b0, 1'b0);

        // write during run is dropped and flags err; table[0] must be intact
        run_stream(2, 1, 2, 1'b1, 1'b0);
        run_stream(1, 1, 0, 1'b0, 1'b0);

        // invalid run requests
        bad_start(0, 1);
        bad_start(DEPTH + 1, 1);
        bad_start(3, 0);

        // asynchronous reset in the middle of a run
        write_entry(0, rand_cmd());
        write_entry(1, rand_cmd());
        cfg_num_entries = (AW+1)'(2);
        cfg_num_iter    = 16'd4;
        start = 1'b1;
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        s_lane_valid = '1;
        s_data  = rand_data();
        tick();
        tick();
        chk("pre_rst_busy", BW'(busy), BW'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mt[i] = '0;
        exp_err  = 1'b0;
        last_cmd = '0;
        // table[0] must read back as zero, table[1] freshly rewritten
        cfg_we    = 1'b1;
        cfg_addr  = AW'(1);
        cfg_wdata = rand_cmd();
        mt[1]     = cfg_wdata;
        tick();
        cfg_we = 1'b0;
        run_stream(2, 1, 0, 1'b0, 1'b0);
        run_stream(1, 1, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/birrd_cmd_issuer.md
BIRRD_CMD_ISSUER -- requirements
Module: birrd_cmd_issuer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one lane.
REQ-002 SHALL have parameter NUM_INPUT_DATA, default 16, number of lanes (power of 2, >=4).
REQ-003 SHALL have parameter COMMAND_WIDTH, default 2, per-switch per-stage command bits.
REQ-004 SHALL have parameter DEPTH, default 8, command-table entries (power of 2).
REQ-005 SHALL derive LEVEL=$clog2(NUM_INPUT_DATA), TOTAL_STAGE=2*LEVEL-1, IN_COMMAND_WIDTH=COMMAND_WIDTH*TOTAL_STAGE, TOTAL_COMMAND=(NUM_INPUT_DATA/2)*IN_COMMAND_WIDTH, AW=$clog2(DEPTH).
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-008 SHALL have port: rst  in  1  asynchronous active-high reset.
REQ-009 SHALL have port: cfg_we  in  1  table write strobe.
REQ-010 SHALL have port: cfg_addr  in  AW  table write address.
REQ-011 SHALL have port: cfg_wdata  in  TOTAL_COMMAND  full-network command word.
REQ-012 SHALL have port: cfg_num_entries  in  AW+1  entries per iteration.
REQ-013 SHALL have port: cfg_num_iter  in  16  iterations over the table.
REQ-014 SHALL have port: start  in  1  single-cycle run request.
REQ-015 SHALL have port: s_valid / s_ready  in / out  1 / 1  upstream beat handshake.
REQ-016 SHALL have port: s_lane_valid  in  NUM_INPUT_DATA  per-lane valid of the beat.
REQ-017 SHALL have port: s_data  in  NUM_INPUT_DATA*DATA_WIDTH  beat data.
REQ-018 SHALL have port: o_valid  out  NUM_INPUT_DATA  to network i_valid.
REQ-019 SHALL have port: o_data_bus  out  NUM_INPUT_DATA*DATA_WIDTH  to network i_data_bus.
REQ-020 SHALL have port: o_en  out  1  to network i_en.
REQ-021 SHALL have port: o_cmd  out  TOTAL_COMMAND  to network i_cmd.
REQ-022 SHALL have ports: busy  out  1  (RUN or DRAIN); done  out  1  completion pulse; err  out  1  sticky config error.

Function
REQ-023 SHALL implement states IDLE, RUN, DRAIN; done is a one-cycle pulse on the DRAIN->IDLE transition.
REQ-024 SHALL write cfg_wdata to table[cfg_addr] when cfg_we=1 and state=IDLE; when busy the write is dropped and err is set.
REQ-025 SHALL, on start in IDLE with 1<=cfg_num_entries<=DEPTH and cfg_num_iter>=1, latch both counts, clear entry/iteration pointers and enter RUN.
REQ-026 SHALL, on start with cfg_num_entries=0, cfg_num_entries>DEPTH or cfg_num_iter=0, set err, stay IDLE, issue no beats and pulse done the next cycle.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL drive s_ready=1 only in RUN, combinationally from state.
REQ-029 SHALL, on handshake (s_valid&s_ready), register next cycle: o_valid=s_lane_valid, o_data_bus=s_data, o_cmd=table[entry ptr]; latency is exactly 1 cycle.
REQ-030 SHALL, in any cycle without a handshake, drive o_valid=0 and o_data_bus=0 and hold o_cmd.
REQ-031 SHALL advance the entry pointer only on handshake, wrapping from num_entries-1 to 0 and incrementing the iteration counter on wrap.
REQ-032 SHALL, on the handshake with entry=num_entries-1 and iteration=num_iter-1, move to DRAIN; s_ready is 0 the following cycle.
REQ-033 SHALL stay in DRAIN exactly TOTAL_STAGE cycles so the last beat exits the network, then go IDLE; for last handshake at cycle T, done=1 at cycle T+TOTAL_STAGE+1.
REQ-034 SHALL drive o_en=1 in RUN and DRAIN, 0 in IDLE.
REQ-035 SHALL clear err only on reset.

Reset
REQ-036 SHALL, while rst=1 (asynchronously, including mid-run), force state IDLE, all counters 0, all table entries 0 (pass-through), o_valid=0, o_data_bus=0, o_cmd=0, o_en=0, s_ready=0, busy=0, done=0, err=0.
REQ-037 SHALL accept start on the first rising edge after rst deasserts.

Verification
REQ-038 SHALL verify: write table[0]=A, table[1]=B, entries=2, iter=2, s_valid always 1 -> o_cmd sequence A,B,A,B on four consecutive cycles starting 1 cycle after first handshake, done at last-handshake+8 (16 lanes).
REQ-039 SHALL verify: s_valid toggling 1,0,1,0 -> o_valid nonzero only in cycles after handshakes, entry pointer unchanged across bubbles, o_cmd held during bubbles.
REQ-040 SHALL verify: start with entries=0 -> no s_ready, no o_valid, done 1 cycle later, err=1.
REQ-041 SHALL verify: cfg_we during RUN -> table unchanged, err=1, run completes normally.
REQ-042 SHALL verify: rst asserted mid-RUN between edges -> all outputs 0 immediately, table reads 0, new run after reset outputs o_cmd=0 until rewritten.
REQ-043 SHALL verify: start asserted during DRAIN -> ignored, exactly one done pulse.
